mem_req_queue: RTL and testbench

- In-order load/store request queue between the EX stage and the dcache.
- Buffers memory ops from EX and issues them one at a time on the dcache's proc2Dcache_* interface.
- Holds each request stable until the dcache asserts finished, then returns load data tagged with the ROB tag.
- A store issues only after the ROB has committed it. A squash discards all uncommitted work.

---
 rtl/mem_req_queue.sv | 207 ++++++++++++++++++++
 tb/tb_mem_req_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_queue.sv
// In-order load/store request queue between EX and the dcache; one op in flight at a time.
// Define MEM_REQ_QUEUE_STATS_EN to add the stat_loads/stat_stores/stat_stall_cycles counters.
module mem_req_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [1:0]       enq_cmd,
  input  logic [XLEN-1:0]  enq_addr,
  input  logic [63:0]      enq_data,
  input  logic [2:0]       enq_size,
  input  logic [TAG_W-1:0] enq_tag,
  input  logic             store_commit,
  input  logic             squash,
  output logic [1:0]       proc2Dcache_command,
  output logic [XLEN-1:0]  proc2Dcache_addr,
  output logic [63:0]      proc2Dcache_data,
  output logic [2:0]       proc2Dcache_size,
  input  logic [63:0]      Dcache_data_out,
  input  logic             finished,
  output logic             ld_valid,
  output logic [TAG_W-1:0] ld_tag,
  output logic [63:0]      ld_data,
  input  logic             ld_ready
`ifdef MEM_REQ_QUEUE_STATS_EN
  ,
  output logic [31:0]      stat_loads,
  output logic [31:0]      stat_stores,
  output logic [31:0]      stat_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP, GAP} state_t;

  state_t state_reg, state_next;

  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg, store_cnt_reg, commit_cnt_reg;
  logic [DEPTH-1:0] is_store_reg;

  logic [XLEN-1:0]  addr_mem [DEPTH];
  logic [63:0]      data_mem [DEPTH];
  logic [2:0]       size_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];

  logic [XLEN-1:0]  out_addr_reg;
  logic [63:0]      out_data_reg;
  logic [2:0]       out_size_reg;
  logic [TAG_W-1:0] op_tag_reg;
  logic             op_store_reg;
  logic             drop_reg;
  logic [TAG_W-1:0] ld_tag_reg;
  logic [63:0]      ld_data_reg;

  logic             enq_fire, deq_fire, deq_store, commit_acc, head_ready, in_issue, issue_start;
  logic [CNT_W-1:0] commit_eff, keep_len, seen;
  logic [DEPTH-1:0] live_store;

  assign enq_ready   = (count_reg != CNT_W'(DEPTH));
  assign enq_fire    = enq_valid && enq_ready && (enq_cmd == 2'd1 || enq_cmd == 2'd2) && !squash;
  assign commit_acc  = store_commit && (commit_cnt_reg < store_cnt_reg);
  assign commit_eff  = commit_cnt_reg + CNT_W'(commit_acc);
  assign head_ready  = (count_reg != '0) && (!is_store_reg[head_reg] || commit_cnt_reg != '0);
  assign in_issue    = (state_reg == ISSUE);
  assign issue_start = (state_reg == IDLE) && (state_next == ISSUE);
  // A squashed load in flight has already left the queue, so its completion must not dequeue.
  assign deq_fire    = in_issue && finished && !drop_reg && !(squash && !op_store_reg);
  assign deq_store   = deq_fire && op_store_reg;

  // Store flags viewed from the head, masked to resident entries.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_live
      assign live_store[gi] = is_store_reg[head_reg + PTR_W'(gi)] && (CNT_W'(gi) < count_reg);
    end
  endgenerate

  // Squash keeps everything up to and including the last committed store.
  always_comb begin
    keep_len = '0;
    seen     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_store[i]) begin
        seen = seen + CNT_W'(1);
        if (seen == commit_eff && commit_eff != '0) keep_len = CNT_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (enq_fire) begin
      addr_mem[tail_reg] <= enq_addr;
      data_mem[tail_reg] <= enq_data;
      size_mem[tail_reg] <= enq_size;
      tag_mem[tail_reg]  <= enq_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      store_cnt_reg  <= '0;
      commit_cnt_reg <= '0;
      is_store_reg   <= '0;
    end else begin
      if (enq_fire) is_store_reg[tail_reg] <= (enq_cmd == 2'd2);
      head_reg <= head_reg + PTR_W'(deq_fire);
      if (squash) begin
        tail_reg       <= head_reg + keep_len[PTR_W-1:0];
        count_reg      <= keep_len - CNT_W'(deq_fire);
        store_cnt_reg  <= commit_eff - CNT_W'(deq_store);
        commit_cnt_reg <= commit_eff - CNT_W'(deq_store);
      end else begin
        tail_reg       <= tail_reg + PTR_W'(enq_fire);
        count_reg      <= count_reg + CNT_W'(enq_fire) - CNT_W'(deq_fire);
        store_cnt_reg  <= store_cnt_reg + CNT_W'(enq_fire && enq_cmd == 2'd2) - CNT_W'(deq_store);
        commit_cnt_reg <= commit_eff - CNT_W'(deq_store);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      out_addr_reg <= '0;
      out_data_reg <= '0;
      out_size_reg <= '0;
      op_tag_reg   <= '0;
      op_store_reg <= 1'b0;
      drop_reg     <= 1'b0;
      ld_tag_reg   <= '0;
      ld_data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (issue_start) begin
        out_addr_reg <= addr_mem[head_reg];
        out_data_reg <= data_mem[head_reg];
        out_size_reg <= size_mem[head_reg];
        op_tag_reg   <= tag_mem[head_reg];
        op_store_reg <= is_store_reg[head_reg];
        drop_reg     <= 1'b0;
      end else if (in_issue && squash && !op_store_reg) begin
        drop_reg <= 1'b1;
      end
      if (in_issue && finished && !op_store_reg && !drop_reg && !squash) begin
        ld_tag_reg  <= op_tag_reg;
        ld_data_reg <= Dcache_data_out;
      end
    end
  end

  always_comb begin
    state_next          = state_reg;
    proc2Dcache_command = 2'd0;
    ld_valid            = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (head_ready && !squash) state_next = ISSUE;
      end
      ISSUE: begin
        proc2Dcache_command = op_store_reg ? 2'd2 : 2'd1;
        if (finished) state_next = (op_store_reg || drop_reg || squash) ? GAP : RESP;
      end
      RESP: begin
        ld_valid = 1'b1;
        if (ld_ready || squash) state_next = GAP;
      end
      GAP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign proc2Dcache_addr = out_addr_reg;
  assign proc2Dcache_data = out_data_reg;
  assign proc2Dcache_size = out_size_reg;
  assign ld_tag           = ld_tag_reg;
  assign ld_data          = ld_data_reg;

`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [31:0] stat_loads_reg, stat_stores_reg, stat_stall_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_loads_reg  <= '0;
      stat_stores_reg <= '0;
      stat_stall_reg  <= '0;
    end else if (in_issue) begin
      if (finished && op_store_reg)  stat_stores_reg <= stat_stores_reg + 32'd1;
      if (finished && !op_store_reg) stat_loads_reg  <= stat_loads_reg + 32'd1;
      if (!finished)                 stat_stall_reg  <= stat_stall_reg + 32'd1;
    end
  end

  assign stat_loads        = stat_loads_reg;
  assign stat_stores       = stat_stores_reg;
  assign stat_stall_cycles = stat_stall_reg;
`endif

endmodule

// File: tb/tb_mem_req_queue.sv
// Bench for mem_req_queue: directed scenarios plus randomized traffic checked against a
// queue-level reference model of the request stream, commits, squashes and load results.
module tb_mem_req_queue;
  localparam int DEPTH = 8;
  localparam int TAG_W = 5;
  localparam int XLEN  = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             enq_valid, enq_ready;
  logic [1:0]       enq_cmd;
  logic [XLEN-1:0]  enq_addr;
  logic [63:0]      enq_data;
  logic [2:0]       enq_size;
  logic [TAG_W-1:0] enq_tag;
  logic             store_commit, squash;
  logic [1:0]       proc2Dcache_command;
  logic [XLEN-1:0]  proc2Dcache_addr;
  logic [63:0]      proc2Dcache_data;
  logic [2:0]       proc2Dcache_size;
  logic [63:0]      Dcache_data_out;
  logic             finished;
  logic             ld_valid;
  logic [TAG_W-1:0] ld_tag;
  logic [63:0]      ld_data;
  logic             ld_ready;
`ifdef MEM_REQ_QUEUE_STATS_EN
  logic [31:0]      stat_loads, stat_stores, stat_stall_cycles;
`endif

  always #5 clock = ~clock;

  mem_req_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_cmd(enq_cmd), .enq_addr(enq_addr),
    .enq_data(enq_data), .enq_size(enq_size), .enq_tag(enq_tag),
    .store_commit(store_commit), .squash(squash),
    .proc2Dcache_command(proc2Dcache_command), .proc2Dcache_addr(proc2Dcache_addr),
    .proc2Dcache_data(proc2Dcache_data), .proc2Dcache_size(proc2Dcache_size),
    .Dcache_data_out(Dcache_data_out), .finished(finished),
    .ld_valid(ld_valid), .ld_tag(ld_tag), .ld_data(ld_data), .ld_ready(ld_ready)
`ifdef MEM_REQ_QUEUE_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  typedef struct {
    bit               st;
    logic [XLEN-1:0]  addr;
    logic [63:0]      data;
    logic [2:0]       size;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             q[$];
  req_t             cur;
  int               commit_m;
  bit               inflight, dropped, pend;
  logic [TAG_W-1:0] pend_tag;
  logic [63:0]      pend_data;
  int               idle_run;
  int               checks = 0;
  int               errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int n_stores();
    int n = 0;
    foreach (q[i]) if (q[i].st) n++;
    return n;
  endfunction

  // Next store may commit only if every older resident entry is an already-committed store.
  function automatic bit commit_legal();
    int seen = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (!q[i].st) return 1'b0;
      seen++;
      if (seen == commit_m + 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Apply what the coming clock edge does to the reference queue.
  task automatic model_step();
    bit commit_acc, fin, enq_acc;
    int commit_eff, keep, seen;
    req_t e;
    if (reset) begin
      q.delete();
      commit_m = 0; inflight = 0; dropped = 0; pend = 0; idle_run = 0;
      return;
    end
    commit_acc = store_commit && (commit_m < n_stores());
    commit_eff = commit_m + (commit_acc ? 1 : 0);
    fin        = inflight && finished;
    enq_acc    = enq_valid && (q.size() < DEPTH) && (enq_cmd == 2'd1 || enq_cmd == 2'd2) && !squash;
    if (pend && (ld_ready || squash)) begin
      if (ld_ready) $display("ld result tag=%0d data=%h", pend_tag, pend_data);
      pend = 0;
    end
    commit_m = commit_eff;
    if (squash) begin
      keep = 0; seen = 0;
      for (int i = 0; i < q.size() && commit_eff > 0; i++) begin
        if (q[i].st) begin
          seen++;
          if (seen == commit_eff) begin keep = i + 1; break; end
        end
      end
      while (q.size() > keep) void'(q.pop_back());
      if (inflight && !cur.st) dropped = 1;
      idle_run = 0;
    end
    if (fin) begin
      $display("op %0s addr=%h tag=%0d%0s", cur.st ? "ST" : "LD", cur.addr, cur.tag,
               dropped ? " dropped" : "");
      if (!dropped && q.size() > 0) begin
        void'(q.pop_front());
        if (cur.st) commit_m--;
      end
      if (!cur.st && !dropped) begin
        pend = 1; pend_tag = cur.tag; pend_data = Dcache_data_out;
      end
      inflight = 0; dropped = 0;
    end
    if (enq_acc) begin
      e.st = (enq_cmd == 2'd2); e.addr = enq_addr; e.data = enq_data;
      e.size = enq_size; e.tag = enq_tag;
      q.push_back(e);
    end
  endtask

  task automatic check_outputs();
    bit issuable;
    check_eq("enq_ready", enq_ready, q.size() < DEPTH);
    check_eq("ld_valid", ld_valid, pend);
    if (pend) begin
      check_eq("ld_tag", ld_tag, pend_tag);
      check_eq("ld_data", ld_data, pend_data);
      check_eq("cmd_in_resp", proc2Dcache_command, 2'd0);
    end else if (proc2Dcache_command != 2'd0 || inflight) begin
      if (!inflight) begin
        inflight = 1; dropped = 0;
        check_eq("issue_nonempty", q.size() != 0, 1'b1);
        if (q.size() != 0) cur = q[0];
        check_eq("issue_allowed", !cur.st || commit_m > 0, 1'b1);
      end
      check_eq("cmd", proc2Dcache_command, cur.st ? 2'd2 : 2'd1);
      check_eq("addr", proc2Dcache_addr, cur.addr);
      check_eq("data", proc2Dcache_data, cur.data);
      check_eq("size", proc2Dcache_size, cur.size);
    end
    issuable = (q.size() > 0) && (!q[0].st || commit_m > 0);
    if (proc2Dcache_command == 2'd0 && !inflight && !pend && issuable) idle_run++;
    else idle_run = 0;
    check_eq("issue_latency", idle_run <= 2, 1'b1);
  endtask

  task automatic tick();
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic clr();
    enq_valid = 0; enq_cmd = 0; enq_addr = 0; enq_data = 0; enq_size = 0; enq_tag = 0;
    store_commit = 0; squash = 0; Dcache_data_out = 0; finished = 0; ld_ready = 0;
  endtask

  task automatic enq(input logic [1:0] c, input logic [XLEN-1:0] a, input logic [63:0] d,
                     input logic [TAG_W-1:0] t);
    enq_valid = 1; enq_cmd = c; enq_addr = a; enq_data = d; enq_size = 3'd3; enq_tag = t;
    tick();
    enq_valid = 0;
  endtask

  task automatic wait_cmd(input string tag, input logic [1:0] c);
    int n = 0;
    while (proc2Dcache_command != c && n < 30) begin tick(); n++; end
    check_eq(tag, proc2Dcache_command, c);
  endtask

  task automatic auto_cycle(input int enq_pct, input int sq_pct);
    int r;
    r = $urandom_range(9);
    enq_valid = ($urandom_range(99) < enq_pct);
    enq_cmd   = (r == 0) ? 2'd0 : (r == 9) ? 2'd3 : (r < 5) ? 2'd1 : 2'd2;
    enq_addr  = $urandom;
    enq_data  = {$urandom, $urandom};
    enq_size  = 3'($urandom_range(7));
    enq_tag   = TAG_W'($urandom_range(31));
    squash    = ($urandom_range(99) < sq_pct);
    store_commit = (commit_legal() && $urandom_range(3) == 0) ||
                   (n_stores() == commit_m && $urandom_range(19) == 0);
    finished  = inflight && ($urandom_range(2) == 0);
    Dcache_data_out = {$urandom, $urandom};
    ld_ready  = ($urandom_range(1) == 1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || inflight || pend) && n < 400) begin
      clr();
      store_commit = commit_legal();
      finished = inflight && ($urandom_range(1) == 1);
      Dcache_data_out = {$urandom, $urandom};
      ld_ready = 1;
      tick();
      n++;
    end
    check_eq("drain_done", n < 400, 1'b1);
    clr();
    tick(); tick();
  endtask

  initial begin
    clr();
    reset = 1;
    @(negedge clock);
    tick(); tick();
    check_eq("rst_cmd", proc2Dcache_command, 2'd0);
    check_eq("rst_addr", proc2Dcache_addr, '0);
    check_eq("rst_enq_ready", enq_ready, 1'b1);
    reset = 0;
    tick();

    // 1: load with 4-cycle dcache latency
    enq(2'd1, 32'h810, 64'h0, 5'd3);
    check_eq("t1_idle", proc2Dcache_command, 2'd0);
    tick();
    check_eq("t1_cmd_first", proc2Dcache_command, 2'd1);
    check_eq("t1_addr", proc2Dcache_addr, 32'h810);
    repeat (3) begin tick(); check_eq("t1_cmd_held", proc2Dcache_command, 2'd1); end
    finished = 1; Dcache_data_out = 64'habcd01101001abcd;
    tick();
    finished = 0;
    check_eq("t1_ld_valid", ld_valid, 1'b1);
    check_eq("t1_ld_tag", ld_tag, 5'd3);
    check_eq("t1_ld_data", ld_data, 64'habcd01101001abcd);
    ld_ready = 1;
    tick();
    ld_ready = 0;
    check_eq("t1_gap", proc2Dcache_command, 2'd0);
    tick();

    // 2: store waits for its commit
    enq(2'd2, 32'h10, 64'hFFFF12344321FFFF, 5'd4);
    repeat (10) begin tick(); check_eq("t2_wait", proc2Dcache_command, 2'd0); end
    store_commit = 1;
    tick();
    store_commit = 0;
    tick();
    check_eq("t2_cmd", proc2Dcache_command, 2'd2);
    check_eq("t2_addr", proc2Dcache_addr, 32'h10);
    check_eq("t2_data", proc2Dcache_data, 64'hFFFF12344321FFFF);
    finished = 1;
    tick();
    finished = 0;
    check_eq("t2_commit_cnt", dut.commit_cnt_reg, 0);
    check_eq("t2_gap", proc2Dcache_command, 2'd0);
    tick();

    // 3: fill to DEPTH, then one completion frees a slot
    for (int i = 0; i < DEPTH; i++) enq(2'd1, 32'h100 + 32'(i * 8), 64'(i), 5'(i));
    check_eq("t3_full", enq_ready, 1'b0);
    enq(2'd1, 32'h200, 64'h0, 5'd20);
    check_eq("t3_count_full", dut.count_reg, DEPTH);
    finished = 1; Dcache_data_out = 64'h1234;
    tick();
    finished = 0;
    check_eq("t3_count", dut.count_reg, DEPTH - 1);
    check_eq("t3_ready", enq_ready, 1'b1);
    ld_ready = 1;
    tick();
    drain();

    // 4: squash while a committed store is in flight
    enq(2'd2, 32'hA0, 64'hAAAA, 5'd1);
    store_commit = 1;
    enq(2'd1, 32'hB0, 64'h0, 5'd2);
    store_commit = 0;
    enq(2'd1, 32'hC0, 64'h0, 5'd3);
    wait_cmd("t4_issue", 2'd2);
    squash = 1;
    tick();
    squash = 0;
    tick();
    check_eq("t4_store_kept", proc2Dcache_command, 2'd2);
    finished = 1;
    tick();
    finished = 0;
    check_eq("t4_count", dut.count_reg, 0);
    repeat (4) begin tick(); check_eq("t4_no_issue", proc2Dcache_command, 2'd0); end

    // 5: result held while consumer stalls
    enq(2'd1, 32'h300, 64'h0, 5'd9);
    enq(2'd1, 32'h308, 64'h0, 5'd10);
    wait_cmd("t5_issue", 2'd1);
    finished = 1; Dcache_data_out = 64'h5555_6666_7777_8888;
    tick();
    finished = 0;
    repeat (5) begin
      tick();
      check_eq("t5_hold_valid", ld_valid, 1'b1);
      check_eq("t5_hold_tag", ld_tag, 5'd9);
      check_eq("t5_hold_data", ld_data, 64'h5555_6666_7777_8888);
    end
    ld_ready = 1;
    tick();
    ld_ready = 0;
    check_eq("t5_gap", proc2Dcache_command, 2'd0);
    tick();
    check_eq("t5_idle", proc2Dcache_command, 2'd0);
    tick();
    check_eq("t5_next", proc2Dcache_command, 2'd1);
    check_eq("t5_next_addr", proc2Dcache_addr, 32'h308);
    drain();

    // 6: reset in the middle of an op
    enq(2'd1, 32'h400, 64'h0, 5'd7);
    wait_cmd("t6_issue", 2'd1);
    reset = 1;
    tick();
    reset = 0;
    check_eq("t6_cmd", proc2Dcache_command, 2'd0);
    check_eq("t6_addr", proc2Dcache_addr, '0);
    check_eq("t6_data", proc2Dcache_data, '0);
    check_eq("t6_size", proc2Dcache_size, '0);
    check_eq("t6_ld_valid", ld_valid, 1'b0);
    check_eq("t6_ld_tag", ld_tag, '0);
    check_eq("t6_ld_data", ld_data, '0);
    check_eq("t6_enq_ready", enq_ready, 1'b1);
`ifdef MEM_REQ_QUEUE_STATS_EN
    check_eq("t6_stat_loads", stat_loads, 0);
    check_eq("t6_stat_stores", stat_stores, 0);
    check_eq("t6_stat_stall", stat_stall_cycles, 0);
`endif
    tick();

    // Randomized traffic
    repeat (2000) auto_cycle(50, 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
